// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: walks start/data/parity/stop against the shared
// edge/bit counter, deserialises LSB-first and flags parity/stop/false-start.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in_i,
  input  logic                  par_en_i,
  input  logic                  par_typ_i,
  input  logic [2:0]            edge_cnt_i,
  input  logic [3:0]            bit_cnt_i,
  input  logic                  sampled_bit_i,
  output logic                  cnt_enable_o,
  output logic                  cnt_clr_o,
  output logic                  samp_en_o,
  output logic [DATA_WIDTH-1:0] p_data_o,
  output logic                  data_valid_o,
  output logic                  par_err_o,
  output logic                  stp_err_o,
  output logic                  strt_glitch_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;

  logic bit_end;
  logic start_det;
  logic exp_par;

  assign bit_end   = (state_q != StIdle) && (edge_cnt_i == 3'd7);
  assign start_det = (state_q == StIdle) && !rx_in_i;
  assign exp_par   = par_typ_q ? ~^shift_q : ^shift_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_in_i) state_d = StStart;
      end
      StStart: begin
        if (bit_end) state_d = sampled_bit_i ? StIdle : StData;
      end
      StData: begin
        // >= so a miscounting counter cannot trap the FSM in DATA
        if (bit_end && (bit_cnt_i >= 4'(DATA_WIDTH))) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_d       = shift_q;
    p_data_d      = p_data_q;
    data_valid_d  = 1'b0;
    strt_glitch_d = 1'b0;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;

    if (start_det) begin
      par_en_d  = par_en_i;
      par_typ_d = par_typ_i;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
    end

    if (bit_end) begin
      unique case (state_q)
        StStart: begin
          if (sampled_bit_i) strt_glitch_d = 1'b1;
        end
        StData: begin
          shift_d = {sampled_bit_i, shift_q[DATA_WIDTH-1:1]};
        end
        StParity: begin
          if (sampled_bit_i != exp_par) par_err_d = 1'b1;
        end
        StStop: begin
          stp_err_d = ~sampled_bit_i;
          if (!par_err_q && sampled_bit_i) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q       <= '0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      p_data_q      <= p_data_d;
      data_valid_q  <= data_valid_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      strt_glitch_q <= strt_glitch_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
    end
  end

  always_comb begin
    cnt_clr_o     = (state_q == StIdle);
    cnt_enable_o  = (state_q != StIdle);
    samp_en_o     = (state_q != StIdle);
    busy_o        = (state_q != StIdle);
    p_data_o      = p_data_q;
    data_valid_o  = data_valid_q;
    par_err_o     = par_err_q;
    stp_err_o     = stp_err_q;
    strt_glitch_o = strt_glitch_q;
  end

endmodule
